// File: rtl/imem_pkg.sv
// Shared definitions for the boot-time instruction store controller.
//   state_t      : controller phase (IDLE, LOAD, FILL, RUN)
//   IMEM_DEPTH   : number of instruction words held
//   NOP          : word the core sees while not running or past the PC limit
//   PC_LIMIT_DEF : default first byte PC that fetches NOP
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int          IMEM_DEPTH   = 16;
  localparam logic [15:0] NOP          = 16'h0000;
  localparam int          PC_LIMIT_DEF = 32;

endpackage

// File: rtl/imem_ram_16x16.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address
//   rdata_o : read data (combinational)
module imem_ram_16x16 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot sequencer and owner of the core's instruction store.
// Loads a program from a valid/ready word stream, zero-fills the unused tail,
// then releases the core (cpu_run). Fetch stays combinational.
// Optional feature macro: LOAD_CHECKSUM_EN (sum of accepted words on ld_checksum).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   load_start          : request a (re)load; honoured in IDLE and RUN only
//   ld_valid/ld_data/ld_last/ld_ready : loader stream
//   pc / instruction    : core fetch port (byte address in, word out)
//   cpu_run             : core may advance
//   load_done           : one-cycle pulse on entry to RUN
//   ld_count            : words accepted in the current/last load (saturates at 16)
//   ld_checksum         : mod-2^16 sum of accepted words (0 when feature disabled)
//   dbg_state           : current controller state, for observation
// Handshake: a word transfers on a rising edge where ld_valid and ld_ready are
// both high; ld_valid must not depend on ld_ready, and ld_data/ld_last are held
// while ld_valid waits for ld_ready.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_run,
  output logic              load_done,
  output logic [4:0]        ld_count,
  output logic [15:0]       ld_checksum,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [4:0]        COUNT_MAX = 5'(IMEM_DEPTH);

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [4:0]          ld_count_q;
  logic                ld_ready_q;
  logic                cpu_run_q;
  logic                load_done_q;

  logic                ld_hs;
  logic                load_entry;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  // ld_ready_q is high exactly while in LOAD, so it qualifies the handshake alone.
  assign ld_hs      = ld_valid & ld_ready_q;
  assign load_entry = load_start & ((state_q == IDLE) | (state_q == RUN));
  assign mem_we     = ld_hs | (state_q == FILL);
  assign mem_wdata  = (state_q == FILL) ? DATA_W'(NOP) : ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      ld_count_q  <= '0;
      ld_ready_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (load_start) begin
            state_q    <= LOAD;
            wr_ptr_q   <= '0;
            ld_count_q <= '0;
            ld_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_hs) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (ld_count_q != COUNT_MAX) ld_count_q <= ld_count_q + 5'd1;
            if (wr_ptr_q == LAST_ADDR) begin
              // Store is full: nothing left to zero-fill.
              state_q     <= RUN;
              ld_ready_q  <= 1'b0;
              cpu_run_q   <= 1'b1;
              load_done_q <= 1'b1;
            end else if (ld_last) begin
              state_q    <= FILL;
              ld_ready_q <= 1'b0;
            end
          end
        end
        FILL: begin
          // Pointer wraps back to 0 on the final fill write.
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_q     <= RUN;
            cpu_run_q   <= 1'b1;
            load_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  imem_ram_16x16 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (mem_wdata),
    .raddr_i (pc[ADDR_W:1]),
    .rdata_o (mem_rdata)
  );

  // pc[0] is a byte offset inside a word and never selects storage.
  assign instruction = ((state_q == RUN) && (pc < 16'(PC_LIMIT))) ? mem_rdata : DATA_W'(NOP);

`ifdef LOAD_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum_q <= '0;
    else if (load_entry) csum_q <= '0;
    else if (ld_hs)      csum_q <= csum_q + 16'(ld_data);
  end

  assign ld_checksum = csum_q;
`else
  assign ld_checksum = NOP;
`endif

  assign ld_ready  = ld_ready_q;
  assign cpu_run   = cpu_run_q;
  assign load_done = load_done_q;
  assign ld_count  = ld_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;
  import imem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = 16'h0000;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [15:0] pc = 16'h0000;
  logic [15:0] instruction;
  logic        cpu_run;
  logic        load_done;
  logic [4:0]  ld_count;
  logic [15:0] ld_checksum;
  state_t      dbg_state;

  imem_load_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_run     (cpu_run),
    .load_done   (load_done),
    .ld_count    (ld_count),
    .ld_checksum (ld_checksum),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;
  int done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the boot phase as a mode plus the words the store must hold.
  localparam int M_IDLE = 0, M_LOAD = 1, M_FILL = 2, M_RUN = 3;
  int          m_mode;
  int          m_ptr;
  int          m_cnt;
  logic [15:0] m_sum;
  logic        m_done;
  logic [15:0] m_mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_ptr = 0; m_cnt = 0; m_sum = 16'h0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode == M_LOAD) begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          m_sum = m_sum + ld_data;
          if (m_cnt < 16) m_cnt = m_cnt + 1;
          if (m_ptr == 15) begin m_mode = M_RUN; m_done = 1'b1; end
          else if (ld_last) m_mode = M_FILL;
          m_ptr = (m_ptr + 1) % 16;
        end
      end else if (m_mode == M_FILL) begin
        m_mem[m_ptr] = 16'h0000;
        if (m_ptr == 15) begin m_mode = M_RUN; m_done = 1'b1; end
        m_ptr = (m_ptr + 1) % 16;
      end else if (load_start) begin
        m_mode = M_LOAD; m_ptr = 0; m_cnt = 0; m_sum = 16'h0;
      end
    end
  end

  function automatic logic [15:0] m_fetch(input logic [15:0] a);
    if (m_mode == M_RUN && a < 16'd32) return m_mem[a[4:1]];
    return 16'h0000;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("cpu_run", 32'(cpu_run), 32'(m_mode == M_RUN));
      chk("ld_ready", 32'(ld_ready), 32'(m_mode == M_LOAD));
      chk("ld_count", 32'(ld_count), 32'(m_cnt));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("instruction", 32'(instruction), 32'(m_fetch(pc)));
`ifdef LOAD_CHECKSUM_EN
      chk("ld_checksum", 32'(ld_checksum), 32'(m_sum));
`else
      chk("ld_checksum", 32'(ld_checksum), 32'h0);
`endif
    end
    if (load_done) done_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; cyc(); load_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    logic took;
    took = 1'b0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    for (int n = 0; n < 40 && !took; n++) begin
      @(negedge clk); took = ld_ready;
      cyc();
    end
    if (!took) chk("handshake_timeout", 32'(took), 32'h1);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_run();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk); seen = cpu_run;
    end
    chk("reach_run", 32'(seen), 32'h1);
    cyc();
  endtask

  task automatic fetch_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    pc = a;
    @(negedge clk);
    chk(name, 32'(instruction), 32'(exp));
    cyc();
  endtask

  logic [15:0] full_w [16];

  initial begin
    for (int i = 0; i < 16; i++) full_w[i] = 16'h3C00 + 16'(i * 3);

    // 1. reset then idle
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cpu_run", 32'(cpu_run), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_ld_count", 32'(ld_count), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    cyc();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cyc(); cyc();

    // 2. short load
    done_pulses = 0;
    pulse_start();
    send_word(16'h8180, 1'b0);
    send_word(16'h2CB2, 1'b0);
    send_word(16'hDC67, 1'b1);
    wait_run();
    repeat (3) cyc();
    chk("short_done_pulses", 32'(done_pulses), 32'h1);
    chk("short_ld_count", 32'(ld_count), 32'd3);
    fetch_chk("short_pc0", 16'd0, 16'h8180);
    fetch_chk("short_pc4", 16'd4, 16'hDC67);
    fetch_chk("short_pc6", 16'd6, 16'h0000);
    fetch_chk("short_pc30", 16'd30, 16'h0000);

    // 3. full load with gaps, no ld_last
    pc = 16'd2;
    load_start = 1'b1; cyc(); load_start = 1'b0;
    @(negedge clk);
    chk("reload_cpu_run", 32'(cpu_run), 32'h0);
    chk("reload_instr", 32'(instruction), 32'h0);
    cyc();
    for (int i = 0; i < 16; i++) begin
      send_word(full_w[i], 1'b0);
      cyc();
    end
    @(negedge clk);
    chk("full_run", 32'(cpu_run), 32'h1);
    chk("full_ready", 32'(ld_ready), 32'h0);
    chk("full_count", 32'(ld_count), 32'd16);
    cyc();
    // extra word offered in RUN must not be taken
    ld_valid = 1'b1; ld_data = 16'hBEEF;
    repeat (3) cyc();
    ld_valid = 1'b0;
    fetch_chk("full_pc30", 16'd30, 16'h3C2D);
    fetch_chk("full_pc32", 16'd32, 16'h0000);
    fetch_chk("full_pc1", 16'd1, 16'h3C00);

    // 4. reload; load_start during LOAD is ignored
    pulse_start();
    send_word(16'h0001, 1'b0);
    load_start = 1'b1; cyc(); load_start = 1'b0;
    send_word(16'hFFFF, 1'b1);
    wait_run();
    chk("reld_count", 32'(ld_count), 32'd2);
`ifdef LOAD_CHECKSUM_EN
    chk("reld_checksum", 32'(ld_checksum), 32'h0000);
`endif
    fetch_chk("reld_pc0", 16'd0, 16'h0001);
    fetch_chk("reld_pc2", 16'd2, 16'hFFFF);
    fetch_chk("reld_pc4", 16'd4, 16'h0000);

    // 5. reset mid-load
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(16'h5A00 + 16'(i), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_run", 32'(cpu_run), 32'h0);
    chk("midrst_ld_count", 32'(ld_count), 32'h0);
    chk("midrst_ready", 32'(ld_ready), 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("midrst_idle_run", 32'(cpu_run), 32'h0);
    cyc();
    pulse_start();
    send_word(16'h1234, 1'b1);
    wait_run();
    fetch_chk("one_pc0", 16'd0, 16'h1234);
    for (int k = 1; k < 16; k++) fetch_chk("one_fill", 16'(2 * k), 16'h0000);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
